// File: rtl/elevator_group_dispatcher.sv
// Two-car hall-call dispatcher: pending call maps, nearest-idle-car arbitration, ack timeout with reassignment.
// Optional fire-service recall (car0 then car1 to floor 0) is built when FIRE_RECALL_EN is defined.
module elevator_group_dispatcher #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
`ifdef FIRE_RECALL_EN
  input  logic       fire_recall,
`endif
  input  logic       hall_valid,
  input  logic [2:0] hall_floor,
  input  logic       hall_dir,
  output logic       hall_ready,
  input  logic [2:0] car0_floor,
  input  logic [2:0] car1_floor,
  input  logic       car0_moving,
  input  logic       car1_moving,
  output logic       car0_asg_valid,
  output logic       car1_asg_valid,
  output logic [2:0] car0_asg_floor,
  output logic [2:0] car1_asg_floor,
  input  logic       car0_asg_ready,
  input  logic       car1_asg_ready,
  output logic [7:0] pending_up,
  output logic [7:0] pending_dn,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    COST,
    ISSUE
`ifdef FIRE_RECALL_EN
    , RECALL
`endif
  } state_t;

  state_t     state, state_n;
  logic [7:0] pend_up_n, pend_dn_n;
  logic [2:0] call_floor, call_floor_n;
  logic       call_dir, call_dir_n;
  logic       car_sel, car_sel_n;
  logic       rr, rr_n;
  logic [1:0] excl, excl_n;
  logic [7:0] tcnt, tcnt_n;
  logic [2:0] up_idx, dn_idx, dist0, dist1;
  logic       elig0, elig1, sel_ready;
  logic [1:0] excl_set;
  logic [7:0] clr_up, clr_dn, set_up, set_dn;
`ifdef FIRE_RECALL_EN
  logic [1:0] recall_done, recall_done_n;
  logic       in_recall;
  assign in_recall = (state == RECALL);
`else
  logic       in_recall;
  assign in_recall = 1'b0;
`endif

  always_comb begin
    up_idx = '0;
    dn_idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (pending_up[i-1]) up_idx = 3'(i - 1);
      if (pending_dn[i-1]) dn_idx = 3'(i - 1);
    end
  end

  assign dist0    = (car0_floor >= call_floor) ? car0_floor - call_floor : call_floor - car0_floor;
  assign dist1    = (car1_floor >= call_floor) ? car1_floor - call_floor : call_floor - car1_floor;
  assign elig0    = !car0_moving && !excl[0];
  assign elig1    = !car1_moving && !excl[1];
  assign sel_ready = car_sel ? car1_asg_ready : car0_asg_ready;
  assign excl_set = excl | (car_sel ? 2'b10 : 2'b01);

  assign hall_ready = !reset && !in_recall;
  assign busy       = (state != IDLE);

  always_comb begin
    car0_asg_valid = (state == ISSUE) && !car_sel;
    car1_asg_valid = (state == ISSUE) && car_sel;
`ifdef FIRE_RECALL_EN
    if (in_recall) begin
      car0_asg_valid = !recall_done[0];
      car1_asg_valid = recall_done[0] && !recall_done[1];
    end
`endif
    car0_asg_floor = (car0_asg_valid && !in_recall) ? call_floor : '0;
    car1_asg_floor = (car1_asg_valid && !in_recall) ? call_floor : '0;
  end

  always_comb begin
    state_n      = state;
    call_floor_n = call_floor;
    call_dir_n   = call_dir;
    car_sel_n    = car_sel;
    rr_n         = rr;
    excl_n       = excl;
    tcnt_n       = tcnt;
    clr_up       = '0;
    clr_dn       = '0;
    set_up       = '0;
    set_dn       = '0;
`ifdef FIRE_RECALL_EN
    recall_done_n = recall_done;
`endif
    case (state)
      IDLE: begin
        if (|pending_up || |pending_dn) begin
          call_dir_n   = |pending_up;
          call_floor_n = (|pending_up) ? up_idx : dn_idx;
          excl_n       = '0;
          state_n      = COST;
        end
      end
      COST: begin
        if (elig0 || elig1) begin
          if (elig0 && elig1)
            car_sel_n = (dist0 < dist1) ? 1'b0 : (dist1 < dist0) ? 1'b1 : rr;
          else
            car_sel_n = elig1;
          tcnt_n  = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (sel_ready) begin
          if (call_dir) clr_up[call_floor] = 1'b1;
          else          clr_dn[call_floor] = 1'b1;
          rr_n    = !rr;
          state_n = IDLE;
        end else if (tcnt == 8'(ACK_TIMEOUT - 1)) begin
          // Excluding the last remaining car re-opens arbitration to both cars.
          excl_n  = (excl_set == 2'b11) ? 2'b00 : excl_set;
          state_n = COST;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end
`ifdef FIRE_RECALL_EN
      RECALL: begin
        if (car0_asg_valid && car0_asg_ready) recall_done_n[0] = 1'b1;
        if (car1_asg_valid && car1_asg_ready) recall_done_n[1] = 1'b1;
        if (!fire_recall && (&recall_done)) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase

    if (hall_valid && hall_ready) begin
      if (hall_dir) set_up[hall_floor] = 1'b1;
      else          set_dn[hall_floor] = 1'b1;
    end
    pend_up_n = (pending_up & ~clr_up) | set_up;
    pend_dn_n = (pending_dn & ~clr_dn) | set_dn;

`ifdef FIRE_RECALL_EN
    if (fire_recall || in_recall) begin
      pend_up_n = '0;
      pend_dn_n = '0;
    end
    if (fire_recall) begin
      state_n = RECALL;
      excl_n  = '0;
      if (!in_recall) recall_done_n = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending_up  <= '0;
      pending_dn  <= '0;
      call_floor  <= '0;
      call_dir    <= 1'b0;
      car_sel     <= 1'b0;
      rr          <= 1'b0;
      excl        <= '0;
      tcnt        <= '0;
`ifdef FIRE_RECALL_EN
      recall_done <= '0;
`endif
    end else begin
      state       <= state_n;
      pending_up  <= pend_up_n;
      pending_dn  <= pend_dn_n;
      call_floor  <= call_floor_n;
      call_dir    <= call_dir_n;
      car_sel     <= car_sel_n;
      rr          <= rr_n;
      excl        <= excl_n;
      tcnt        <= tcnt_n;
`ifdef FIRE_RECALL_EN
      recall_done <= recall_done_n;
`endif
    end
  end

endmodule

// File: tb/tb_elevator_group_dispatcher.sv
// Directed bench for elevator_group_dispatcher: per-cycle compare against a behavioural model plus literal checks.
module tb_elevator_group_dispatcher;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hall_valid = 1'b0;
  logic [2:0] hall_floor = '0;
  logic       hall_dir = 1'b0;
  logic       hall_ready;
  logic [2:0] car0_floor = '0, car1_floor = '0;
  logic       car0_moving = 1'b0, car1_moving = 1'b0;
  logic       car0_asg_valid, car1_asg_valid;
  logic [2:0] car0_asg_floor, car1_asg_floor;
  logic       car0_asg_ready = 1'b0, car1_asg_ready = 1'b0;
  logic [7:0] pending_up, pending_dn;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_group_dispatcher #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .hall_valid(hall_valid), .hall_floor(hall_floor), .hall_dir(hall_dir), .hall_ready(hall_ready),
    .car0_floor(car0_floor), .car1_floor(car1_floor),
    .car0_moving(car0_moving), .car1_moving(car1_moving),
    .car0_asg_valid(car0_asg_valid), .car1_asg_valid(car1_asg_valid),
    .car0_asg_floor(car0_asg_floor), .car1_asg_floor(car1_asg_floor),
    .car0_asg_ready(car0_asg_ready), .car1_asg_ready(car1_asg_ready),
    .pending_up(pending_up), .pending_dn(pending_dn), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 waiting, 1 choosing a car, 2 offering to a car.
  int       m_phase = 0, m_floor = 0, m_car = 0, m_rr = 0, m_wait = 0;
  bit       m_up = 0;
  bit [7:0] m_pu = '0, m_pd = '0;
  bit [1:0] m_ex = '0;

  always @(posedge clk) begin
    bit [7:0] nu, nd;
    bit e0, e1;
    int d0, d1;
    if (reset) begin
      m_phase = 0; m_pu = '0; m_pd = '0; m_rr = 0; m_ex = '0; m_wait = 0; m_car = 0; m_floor = 0;
    end else begin
      nu = m_pu; nd = m_pd;
      if (m_phase == 0) begin
        if (m_pu != 0 || m_pd != 0) begin
          m_up = (m_pu != 0);
          for (int f = 7; f >= 0; f--) if (m_up ? m_pu[f] : m_pd[f]) m_floor = f;
          m_ex = '0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_ex == 2'b11) m_ex = '0;
        e0 = !car0_moving && !m_ex[0];
        e1 = !car1_moving && !m_ex[1];
        d0 = int'(car0_floor) - m_floor; if (d0 < 0) d0 = -d0;
        d1 = int'(car1_floor) - m_floor; if (d1 < 0) d1 = -d1;
        if (e0 || e1) begin
          if (e0 && e1) m_car = (d0 < d1) ? 0 : (d1 < d0) ? 1 : m_rr;
          else          m_car = e1 ? 1 : 0;
          m_wait = 0;
          m_phase = 2;
        end
      end else begin
        if ((m_car == 0) ? car0_asg_ready : car1_asg_ready) begin
          if (m_up) nu[m_floor] = 0; else nd[m_floor] = 0;
          m_rr = 1 - m_rr;
          m_phase = 0;
        end else begin
          m_wait++;
          if (m_wait == TO) begin m_ex[m_car] = 1; m_phase = 1; end
        end
      end
      if (hall_valid) begin
        if (hall_dir) nu[hall_floor] = 1; else nd[hall_floor] = 1;
      end
      m_pu = nu; m_pd = nd;
    end
  end

  always @(posedge clk) begin
    bit v0, v1;
    #1;
    v0 = (m_phase == 2) && (m_car == 0);
    v1 = (m_phase == 2) && (m_car == 1);
    chk("model_hall_ready", hall_ready, !reset);
    chk("model_busy", busy, m_phase != 0);
    chk("model_pending_up", pending_up, m_pu);
    chk("model_pending_dn", pending_dn, m_pd);
    chk("model_car0_valid", car0_asg_valid, v0);
    chk("model_car1_valid", car1_asg_valid, v1);
    chk("model_car0_floor", car0_asg_floor, v0 ? m_floor : 0);
    chk("model_car1_floor", car1_asg_floor, v1 ? m_floor : 0);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_hall_ready", hall_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pending", {pending_up, pending_dn}, 0);
    chk("reset_valids", {car0_asg_valid, car1_asg_valid}, 0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic hall_call(input int f, input bit d);
    hall_valid = 1'b1; hall_floor = 3'(f); hall_dir = d;
    @(negedge clk);
    hall_valid = 1'b0;
  endtask

  task automatic wait_offer(input string nm, input int exp_car, input int exp_floor);
    int n = 0;
    while (!car0_asg_valid && !car1_asg_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_offer_seen"}, n < 60, 1);
    chk({nm, "_car"}, car1_asg_valid ? 1 : 0, exp_car);
    chk({nm, "_floor"}, car1_asg_valid ? car1_asg_floor : car0_asg_floor, exp_floor);
  endtask

  task automatic ack(input int c);
    if (c == 0) car0_asg_ready = 1'b1; else car1_asg_ready = 1'b1;
    @(negedge clk);
    car0_asg_ready = 1'b0; car1_asg_ready = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);

    // Nearest car, two-cycle latency, then same-cycle set beats clear
    do_reset();
    car0_floor = 3'd1; car1_floor = 3'd6;
    hall_call(5, 1);
    chk("near_pending_set", pending_up, 8'h20);
    @(negedge clk);
    chk("near_cost_busy", busy, 1);
    chk("near_cost_novalid", {car0_asg_valid, car1_asg_valid}, 0);
    @(negedge clk);
    chk("near_car1_valid", car1_asg_valid, 1);
    chk("near_car1_floor", car1_asg_floor, 5);
    chk("near_car0_idle", car0_asg_valid, 0);
    hall_valid = 1'b1; hall_floor = 3'd5; hall_dir = 1'b1; car1_asg_ready = 1'b1;
    @(negedge clk);
    hall_valid = 1'b0; car1_asg_ready = 1'b0;
    chk("setwins_valid_drop", car1_asg_valid, 0);
    chk("setwins_pending", pending_up, 8'h20);
    wait_offer("redispatch", 1, 5);
    ack(1);
    chk("redispatch_cleared", pending_up, 0);

    // Tie broken by round-robin
    do_reset();
    car0_floor = 3'd3; car1_floor = 3'd3;
    hall_call(0, 0);
    wait_offer("tie_rr0", 0, 0);
    ack(0);
    hall_call(7, 1);
    wait_offer("tie_rr1", 1, 7);
    ack(1);
    chk("tie_pending_clear", {pending_up, pending_dn}, 0);

    // Ack timeout, reassignment, then reset mid-offer
    do_reset();
    car0_floor = 3'd3; car1_floor = 3'd7;
    hall_call(4, 1);
    wait_offer("to_first", 0, 4);
    n = 0;
    while (car0_asg_valid && n < 40) begin @(negedge clk); n++; end
    chk("to_valid_cycles", n, TO);
    wait_offer("to_reassign", 1, 4);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_valid", car1_asg_valid, 0);
    chk("midreset_floor", car1_asg_floor, 0);
    chk("midreset_pending", pending_up, 0);
    reset = 1'b0;
    @(negedge clk);

    // Stall with both cars moving, then scan order across both maps
    do_reset();
    car0_floor = 3'd3; car1_floor = 3'd3; car0_moving = 1'b1; car1_moving = 1'b1;
    hall_call(3, 1);
    repeat (8) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_novalid", {car0_asg_valid, car1_asg_valid}, 0);
    hall_call(0, 1);
    hall_call(2, 1);
    hall_call(7, 0);
    chk("order_pend_up", pending_up, 8'h0D);
    chk("order_pend_dn", pending_dn, 8'h80);
    car0_moving = 1'b0;
    wait_offer("unstall", 0, 3);
    ack(0);
    chk("order_pend_up_after", pending_up, 8'h05);
    wait_offer("order_0up", 0, 0);
    ack(0);
    wait_offer("order_2up", 0, 2);
    ack(0);
    wait_offer("order_7dn", 0, 7);
    ack(0);
    chk("order_drained", {pending_up, pending_dn}, 0);
    chk("order_idle", busy, 0);
    car1_moving = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
